// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: synchronises and glitch-filters the PS/2 lines,
// frames 11-bit packets with start/stop/odd-parity checks, folds E0/F0
// prefixes into {ext,rel,code} key events and queues them in a
// first-word-fall-through FIFO with a valid/ready handshake.
module ps2_key_event_rx #(
  parameter int CLK_DIV       = 250,
  parameter int FILTER_LEN    = 4,
  parameter int TIMEOUT_TICKS = 4000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  input  logic       EVT_READY,
  input  logic       CLR_STATUS,
  output logic       EVT_VALID,
  output logic [7:0] EVT_CODE,
  output logic       EVT_EXT,
  output logic       EVT_REL,
  output logic       FRAME_ERR,
  output logic [7:0] ERR_CNT,
  output logic       OVERFLOW
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

  state_t           state, state_nxt;
  logic             clk_s1, clk_s2, dat_s1, dat_s2;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             clk_flt;
  logic [FLT_W-1:0] flt_cnt;
  logic             flt_flip, fall;
  logic [10:0]      shreg;
  logic [3:0]       bit_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_expire;
  logic             frame_ok;
  logic [7:0]       rx_byte;
  logic             err_evt, byte_ok, push_req;
  logic             ext_flag, rel_flag;
  logic [9:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             full, empty, pop, wr_en;
  logic [9:0]       head;

  // Two-flop synchronisers for the asynchronous PS/2 lines; idle-high reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      dat_s1 <= PS2_DATA;
      dat_s2 <= dat_s1;
    end
  end

  // Sample-tick divider: one-CLK pulse every CLK_DIV cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  // The filtered clock follows the synced clock only after FILTER_LEN
  // consecutive ticks that disagree with it; a falling flip is a bit strobe.
  assign flt_flip = tick && (clk_s2 != clk_flt) && (flt_cnt == FLT_W'(FILTER_LEN - 1));
  assign fall     = flt_flip && !clk_s2;

  // Glitch filter counter and filtered clock.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_flt <= 1'b1;
      flt_cnt <= '0;
    end else if (tick) begin
      if (clk_s2 == clk_flt) begin
        flt_cnt <= '0;
      end else if (flt_flip) begin
        clk_flt <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FLT_W'(1);
      end
    end
  end

  assign tmo_expire = tick && !fall && (tmo_cnt == TMO_W'(TIMEOUT_TICKS - 1));
  // Frame layout after 11 LSB-first shifts: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  assign frame_ok   = !shreg[0] && shreg[10] && (^shreg[9:1]);
  assign rx_byte    = shreg[8:1];

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (fall && !dat_s2) state_nxt = S_RECV;
      S_RECV: begin
        if (fall && (bit_cnt == 4'd10)) state_nxt = S_CHECK;
        else if (tmo_expire)            state_nxt = S_IDLE;
      end
      S_CHECK: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: frame error strobe and accepted byte / event push request.
  always_comb begin
    err_evt  = 1'b0;
    byte_ok  = 1'b0;
    push_req = 1'b0;
    unique case (state)
      S_RECV:  err_evt = tmo_expire;
      S_CHECK: begin
        err_evt  = !frame_ok;
        byte_ok  = frame_ok;
        push_req = frame_ok && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);
      end
      default: ;
    endcase
  end

  // Frame shift register, bit counter and inter-edge timeout counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg   <= '0;
      bit_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (fall && !dat_s2) begin
          shreg   <= {dat_s2, 10'b0};
          bit_cnt <= 4'd1;
          tmo_cnt <= '0;
        end
        S_RECV: begin
          if (fall) begin
            shreg   <= {dat_s2, shreg[10:1]};
            bit_cnt <= bit_cnt + 4'd1;
            tmo_cnt <= '0;
          end else if (tick) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Prefix flags: set by E0/F0, consumed by the next key byte, dropped on a bad frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ext_flag <= 1'b0;
      rel_flag <= 1'b0;
    end else if (state == S_CHECK) begin
      if (!byte_ok) begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end else if (rx_byte == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (rx_byte == 8'hF0) begin
        rel_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && EVT_READY;
  // A push into a full FIFO still lands when the head is popped in the same cycle.
  assign wr_en = push_req && (!full || pop);

  // Event storage.
  // NOTE: the storage array is not reset; the pointers define which entries
  // are meaningful and the outputs are masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {ext_flag, rel_flag, rx_byte};
  end

  // FIFO pointers, one extra bit to tell full from empty.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Status: error pulse, saturating error count, sticky overflow; clear wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FRAME_ERR <= 1'b0;
      ERR_CNT   <= '0;
      OVERFLOW  <= 1'b0;
    end else begin
      FRAME_ERR <= err_evt;
      if (CLR_STATUS) begin
        ERR_CNT  <= '0;
        OVERFLOW <= 1'b0;
      end else begin
        if (err_evt && (ERR_CNT != 8'hFF)) ERR_CNT <= ERR_CNT + 8'd1;
        if (push_req && full && !pop)      OVERFLOW <= 1'b1;
      end
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign EVT_VALID = !empty;
  assign EVT_CODE  = EVT_VALID ? head[7:0] : 8'h00;
  assign EVT_EXT   = EVT_VALID && head[9];
  assign EVT_REL   = EVT_VALID && head[8];

endmodule
